rggen_axi4lite_master: RTL
==========================

// Module: rggen_axi4lite_master
// PURPOSE
// - AXI4-Lite initiator: turns one request at a time from a simple valid/ready command port into
//   AXI4-Lite write (AW+W->B) or read (AR->R) transactions.
// - Returns the response on a valid/ready response port.
// - Drives register blocks from test/firmware-model logic; opposite end of the register-block slave port.
// PARAMETERS
// - ADDRESS_WIDTH  16  byte address width of req_addr/awaddr/araddr
// - DATA_WIDTH     32  data width; 32 or 64 only; strobe width DATA_WIDTH/8
// PORTS
// - clk          in   1              clock; one clock; reset is synchronous and active-high
// - rst          in   1              synchronous active-high reset
// - req_valid    in   1              command valid
// - req_ready    out  1              command accepted when req_valid&&req_ready
// - req_write    in   1              1=write, 0=read
// - req_addr     in   ADDRESS_WIDTH  byte address
// - req_wdata    in   DATA_WIDTH     write data (ignored for reads)
// - req_wstrb    in   DATA_WIDTH/8   write strobes (ignored for reads)
// - req_prot     in   3              copied to awprot/arprot
// - rsp_valid    out  1              response valid
// - rsp_ready    in   1              response consumed when rsp_valid&&rsp_ready
// - rsp_write    out  1              response belongs to a write
// - rsp_rdata    out  DATA_WIDTH     read data (0 for writes)
// - rsp_resp     out  2              AXI resp code (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
// - awvalid/awready/awaddr/awprot, wvalid/wready/wdata/wstrb, bvalid/bready/bresp,
// - arvalid/arready/araddr/arprot, rvalid/rready/rdata/rresp: AXI4-Lite master side, standard widths
// BEHAVIOUR
// - Reset values: every valid/ready output 0; awaddr/araddr/wdata/rsp_rdata 0; wstrb 0;
//   awprot/arprot 0; rsp_resp 0; rsp_write 0; FSM in IDLE.
// - FSM states: IDLE, WRITE, WAIT_B, READ, WAIT_R, RESPOND.
// - IDLE: req_ready=1 (combinational from state only).
//   - Accept, write: register addr/data/strb/prot; next cycle awvalid=wvalid=1; ->WRITE.
//   - Accept, read: arvalid=1 next cycle; ->READ.
// - WRITE: AW and W handshake independently; each valid drops the cycle after its own handshake.
//   - Handshakes in the same or different cycles both legal.
//   - ->WAIT_B once both done; bready=1 from the cycle both are done, held in WAIT_B.
//   - bvalid early (before AW/W both done) is ignored until both complete.
// - READ: arvalid held until arready; ->WAIT_R with rready=1.
// - WAIT_B/WAIT_R: on bvalid/rvalid handshake capture bresp/rresp (and rdata); ready drops next cycle;
//   ->RESPOND with rsp_valid=1.
// - RESPOND: rsp_valid and rsp_* held stable until rsp_ready; then ->IDLE.
//   - New request accepted the cycle after, not the same cycle.
// - AXI rules: a valid never waits on its ready; once high, valid and payload held stable until handshake.
// - Only one transaction outstanding; ID-free; no pipelining.
// - Minimum latency, zero-wait slave: accept@0, AW/W@1, B@2, rsp_valid@3; read identical via AR/R.
// - No timeout: a slave that never responds stalls the block until rst.
// - rst mid-transaction: all outputs return to reset values next edge.
//   The in-flight transaction is abandoned; the system resets the slave too.
// CONFIGURATION
// - RGGEN_AXI4LITE_MASTER_ALIGN_CHECK_EN defined: request with req_addr not aligned to DATA_WIDTH/8
//   - No AXI channel is driven.
//   - FSM goes IDLE->RESPOND; rsp_resp=SLVERR(2), rsp_rdata=0, rsp_valid one cycle after accept.
// - Undefined: address forwarded unmodified; no local error generation.
// STRUCTURE
// - rggen_axi4lite_master_pkg:
//   - typedef enum logic [2:0] state (IDLE..RESPOND)
//   - typedef enum logic [1:0] resp (OKAY, EXOKAY, SLVERR, DECERR)
// - Single module, no sub-module; AW/W done flags and the FSM live in one always_ff.
// TESTING
// - Zero-wait write addr=0x0010, data=0xDEADBEEF, strb=0xF -> AW/W same cycle, B OKAY;
//   rsp_valid at cycle 3, rsp_resp=0.
// - Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle,
//   awvalid held 4 cycles with awaddr stable; bready only after both done.
// - Read addr=0x0020, slave returns rdata=0x12345678 with rresp=SLVERR after 2 wait cycles
//   -> rsp_rdata=0x12345678, rsp_resp=2, rsp_write=0.
// - Response backpressure: rsp_ready low 5 cycles -> rsp_* stable, req_ready=0 throughout,
//   no new AXI valid asserted.
// - Assert rst while awvalid=1 -> next cycle all AXI valids/readies 0, FSM IDLE, req_ready=1.
// - RGGEN_AXI4LITE_MASTER_ALIGN_CHECK_EN: read addr=0x0013 -> no arvalid, rsp_resp=2, rsp_rdata=0;
//   without macro -> araddr=0x0013 driven.

Source files
------------

// File: rtl/rggen_axi4lite_master_pkg.sv
// rtl/rggen_axi4lite_master_pkg.sv - shared types for the AXI4-Lite initiator
package rggen_axi4lite_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT_B,
    ST_READ,
    ST_WAIT_R,
    ST_RESPOND
  } state_e;

  typedef enum logic [1:0] {
    RESP_OKAY,
    RESP_EXOKAY,
    RESP_SLVERR,
    RESP_DECERR
  } resp_e;

endpackage

// File: rtl/rggen_axi4lite_master_if.sv
// rtl/rggen_axi4lite_master_if.sv - command/response port plus AXI4-Lite master channels
// The master modport is the initiator's view; slave is the requester/register-block view.
interface rggen_axi4lite_master_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDRESS_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_wstrb;
  logic [2:0]                req_prot;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_write;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic [1:0]                rsp_resp;

  logic                      awvalid;
  logic                      awready;
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, req_prot,
    output req_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  rsp_ready,
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp,
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output rsp_ready,
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp,
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/rggen_axi4lite_master.sv
// rtl/rggen_axi4lite_master.sv - single-outstanding AXI4-Lite initiator driven by a valid/ready command port
// Optional RGGEN_AXI4LITE_MASTER_ALIGN_CHECK_EN answers misaligned requests locally with SLVERR.
module rggen_axi4lite_master
  import rggen_axi4lite_master_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  rggen_axi4lite_master_if.master bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB_WIDTH  = $clog2(STRB_WIDTH);

  state_e                    state_q, state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
  logic [2:0]                prot_q, prot_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      misaligned;

`ifdef RGGEN_AXI4LITE_MASTER_ALIGN_CHECK_EN
  assign misaligned = |bus.req_addr[LSB_WIDTH-1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    prot_d      = prot_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          wstrb_d     = bus.req_wstrb;
          prot_d      = bus.req_prot;
          rsp_write_d = bus.req_write;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_resp_d  = RESP_SLVERR;
            rsp_rdata_d = '0;
            state_d     = ST_RESPOND;
          end else if (bus.req_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (awvalid_q && bus.awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && bus.wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // bready only opens once both address and data have been taken
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (bus.bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = bus.bresp;
          rsp_rdata_d = '0;
          state_d     = ST_RESPOND;
        end
      end
      ST_READ: begin
        if (arvalid_q && bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (bus.rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = bus.rresp;
          rsp_rdata_d = bus.rdata;
          state_d     = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      prot_q      <= prot_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.awvalid   = awvalid_q;
  assign bus.awaddr    = addr_q;
  assign bus.awprot    = prot_q;
  assign bus.wvalid    = wvalid_q;
  assign bus.wdata     = wdata_q;
  assign bus.wstrb     = wstrb_q;
  assign bus.bready    = bready_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = addr_q;
  assign bus.arprot    = prot_q;
  assign bus.rready    = rready_q;

endmodule
